vvm_ftw_sequencer: RTL and testbench
====================================

Name: vvm_ftw_sequencer

Overview:
- Sequences LO frequency-tuning-word (FTW) updates into the vvm_dsp down-converter.
- Holds host-written shadow FTWs for the four channels and applies them atomically on a decimated-frame boundary with a single update_ftw pulse.
- Gates a measurement-valid flag until a programmable number of result frames has passed, so the CIC/IIR transients after a retune are discarded.
- Optional sweep mode steps all four FTWs by a common increment across N points, one settled measurement window per point.

Parameters:
- W_FTW, 32, FTW width.
- W_PTS, 16, width of the sweep point count and point index.
- W_SETTLE, 4, width of the settle frame count.

Ports:
- sample_clk  in  1  sample clock; the single clock, shared with vvm_dsp.
- sample_rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  shadow register write strobe.
- wr_addr  in  2  channel select, 0..3.
- wr_data  in  W_FTW  shadow FTW value.
- commit  in  1  start apply (single point or sweep).
- abort  in  1  cancel the sequence.
- sweep_en  in  1  sweep mode; sampled at commit.
- ftw_step  in  W_FTW  sweep increment; sampled at commit.
- sweep_points  in  W_PTS  number of sweep points; 0 is treated as 1; sampled at commit.
- settle_frames  in  W_SETTLE  frames to discard after each apply; sampled at commit.
- frame_strobe  in  1  decimated result strobe from vvm_dsp, one cycle per frame.
- ftws_0..ftws_3  out  W_FTW each  active FTWs to vvm_dsp.
- update_ftw  out  1  one-cycle load pulse to vvm_dsp.
- busy  out  1  sequence in progress.
- meas_valid  out  1  results downstream correspond to the current active FTWs and have settled.
- point_idx  out  W_PTS  current sweep point, 0-based.
- sweep_done  out  1  one-cycle pulse at completion of the sequence.
- commit_err  out  1  one-cycle pulse when commit is ignored.

Behaviour:
- Reset (asynchronous, sample_rst_n low): all shadow regs, ftws_*, point_idx and counters go to 0; update_ftw, busy, meas_valid, sweep_done and commit_err go to 0; state IDLE. Reset asserted mid-sequence returns here immediately. No update_ftw is emitted on reset exit.
- Shadow writes: wr_en writes shadow[wr_addr] in every state. A write updates the shadow only, never ftws_* directly.
- All outputs are registered.
- States: IDLE, WAIT_FRAME, APPLY, SETTLE, HOLD.
- IDLE:
  - commit → WAIT_FRAME. Latch sweep_en, ftw_step, settle_frames and max(sweep_points,1). point_idx←0.
  - busy=1 and meas_valid=0 from the next cycle.
- commit while busy: ignored; commit_err pulses one cycle later.
- WAIT_FRAME: wait for frame_strobe. If the strobe is high in cycle N, state = APPLY in cycle N+1.
- APPLY (exactly one cycle):
  - ftws_* and update_ftw=1 change together in this cycle.
  - Point 0 loads the shadow values as registered at the end of cycle N-1; a write coincident with the strobe is excluded.
  - Point k>0 loads ftws_i+ftw_step, modulo 2^W_FTW (wrap, no saturation).
  - → SETTLE, with the frame counter cleared.
  - A frame_strobe during APPLY is not counted.
- SETTLE:
  - Count frame_strobe. When the count reaches settle_frames, assert meas_valid the next cycle.
  - settle_frames=0: meas_valid asserts in the cycle after APPLY.
  - Then, if points remain → HOLD; otherwise → IDLE with busy=0, meas_valid held 1, and a sweep_done pulse coincident with busy falling.
- HOLD (sweep only):
  - meas_valid=1 for one measurement frame.
  - The next frame_strobe drops meas_valid and increments point_idx, and the state goes directly to APPLY. No extra WAIT_FRAME: a strobe in cycle M gives APPLY in cycle M+1.
- meas_valid is cleared by a new commit, abort or reset.
- abort (any state except IDLE): next cycle IDLE, busy=0, meas_valid=0, ftws_* retain their current values, no update_ftw, no sweep_done.
  - abort and commit in the same cycle: abort wins.
  - abort in IDLE: no effect.
- Single-point latency: commit to update_ftw is 2 cycles minimum (commit cycle, then a strobe in the following WAIT_FRAME cycle).
- update_ftw is never high for two consecutive cycles.

Decomposition:
- Shared package vvm_pkg:
  - W_FTW.
  - State enum {IDLE, WAIT_FRAME, APPLY, SETTLE, HOLD}.
  - N_CH = 4.
- One natural sub-module: vvm_frame_counter, a loadable down-counter on frame_strobe with done flag. Used for settle counting.
- Top level: FSM, shadow bank and step adders.

Test Plan:
- Single apply:
  - Stimulus: write shadow 0x10000000/0x20000000/0x30000000/0x40000000, commit, settle_frames=2, strobe every 100 cycles.
  - Response: ftws_* take these values one cycle after the first strobe, with update_ftw high for that one cycle. meas_valid rises one cycle after the 2nd subsequent strobe. busy falls together with a sweep_done pulse.
- Sweep wrap:
  - Stimulus: shadow all 0xFFFFFFF0, ftw_step=0x10, sweep_points=3, settle_frames=1.
  - Response: FTWs go 0xFFFFFFF0 → 0x00000000 → 0x00000010. point_idx 0,1,2. Exactly 3 update_ftw pulses. One sweep_done.
- settle_frames=0 and sweep_points=0:
  - Response: one apply only; meas_valid in the cycle after APPLY; sweep_done asserted.
- Write coincident with strobe:
  - Stimulus: wr_en (addr 1, 0xAAAA0000) in the same cycle as the frame_strobe that triggers APPLY.
  - Response: ftws_1 gets the old shadow value. The next commit applies 0xAAAA0000.
- Abort and collisions:
  - Abort during SETTLE → IDLE next cycle, busy=0, meas_valid=0, ftws_* unchanged, no sweep_done.
  - Commit while busy → commit_err pulse, sequence unaffected.
- Async reset mid-sweep:
  - Stimulus: drop sample_rst_n between clock edges during HOLD.
  - Response: all outputs 0 immediately, without waiting for a clock edge. No update_ftw after release.

Source files
------------

// File: rtl/vvm_pkg.sv
`default_nettype none
// =============================================================================
// vvm_pkg : shared widths, channel count and sequencer state encoding
// Rev 1.0
// =============================================================================
package vvm_pkg;

    localparam int W_FTW = 32;
    localparam int N_CH  = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        APPLY      = 3'd2,
        SETTLE     = 3'd3,
        HOLD       = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/vvm_frame_counter.sv
`default_nettype none
// =============================================================================
// vvm_frame_counter : loadable down-counter of frame strobes with expiry flag
// Rev 1.0
// =============================================================================
module vvm_frame_counter
    import vvm_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         count_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;

    // Expiry flags the strobe that consumes the last remaining frame.
    assign expire_o = count_i && (count_q == W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vvm_ftw_sequencer.sv
`default_nettype none
// =============================================================================
// vvm_ftw_sequencer : frame-aligned atomic FTW apply, settle gating and sweep
// Rev 1.0
// =============================================================================
module vvm_ftw_sequencer
    import vvm_pkg::*;
#(
    parameter int W_FTW    = vvm_pkg::W_FTW,
    parameter int W_PTS    = 16,
    parameter int W_SETTLE = 4
) (
    input  logic                sample_clk_i,
    input  logic                sample_rst_n_i,
    input  logic                wr_en_i,
    input  logic [1:0]          wr_addr_i,
    input  logic [W_FTW-1:0]    wr_data_i,
    input  logic                commit_i,
    input  logic                abort_i,
    input  logic                sweep_en_i,
    input  logic [W_FTW-1:0]    ftw_step_i,
    input  logic [W_PTS-1:0]    sweep_points_i,
    input  logic [W_SETTLE-1:0] settle_frames_i,
    input  logic                frame_strobe_i,
    output logic [W_FTW-1:0]    ftws_0_o,
    output logic [W_FTW-1:0]    ftws_1_o,
    output logic [W_FTW-1:0]    ftws_2_o,
    output logic [W_FTW-1:0]    ftws_3_o,
    output logic                update_ftw_o,
    output logic                busy_o,
    output logic                meas_valid_o,
    output logic [W_PTS-1:0]    point_idx_o,
    output logic                sweep_done_o,
    output logic                commit_err_o
);

    state_e                state_q, state_d;
    logic [W_FTW-1:0]      shadow_q [N_CH];
    logic [W_FTW-1:0]      ftws_q   [N_CH];
    logic [W_FTW-1:0]      ftws_d   [N_CH];
    logic [W_FTW-1:0]      ftws_step_w [N_CH];
    logic                  update_q, update_d;
    logic                  busy_q, busy_d;
    logic                  meas_q, meas_d;
    logic [W_PTS-1:0]      pidx_q, pidx_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  sweep_q, sweep_d;
    logic [W_FTW-1:0]      step_q, step_d;
    logic [W_SETTLE-1:0]   settle_q, settle_d;
    logic [W_PTS-1:0]      npts_q, npts_d;
    logic                  cnt_load, cnt_en, cnt_expire;
    logic                  finish;
    logic                  last_point;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_step
            assign ftws_step_w[gi] = ftws_q[gi] + step_q;
        end
    endgenerate

    assign last_point = !sweep_q || (pidx_q == (npts_q - W_PTS'(1)));

    vvm_frame_counter #(
        .W (W_SETTLE)
    ) u_settle_cnt (
        .clk_i      (sample_clk_i),
        .rst_n_i    (sample_rst_n_i),
        .load_i     (cnt_load),
        .load_val_i (settle_q),
        .count_i    (cnt_en),
        .expire_o   (cnt_expire)
    );

    always_comb begin
        state_d  = state_q;
        ftws_d   = ftws_q;
        update_d = 1'b0;
        busy_d   = busy_q;
        meas_d   = meas_q;
        pidx_d   = pidx_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        sweep_d  = sweep_q;
        step_d   = step_q;
        settle_d = settle_q;
        npts_d   = npts_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (commit_i && !abort_i) begin
                    state_d  = WAIT_FRAME;
                    busy_d   = 1'b1;
                    meas_d   = 1'b0;
                    pidx_d   = '0;
                    sweep_d  = sweep_en_i;
                    step_d   = ftw_step_i;
                    settle_d = settle_frames_i;
                    npts_d   = (sweep_points_i == '0) ? W_PTS'(1) : sweep_points_i;
                end
            end
            WAIT_FRAME: begin
                // Shadow is read before this cycle's write lands, so a coincident write is excluded.
                if (frame_strobe_i) begin
                    state_d  = APPLY;
                    ftws_d   = shadow_q;
                    update_d = 1'b1;
                end
            end
            APPLY: begin
                cnt_load = 1'b1;
                if (settle_q == '0) begin
                    finish = 1'b1;
                end else begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_en = frame_strobe_i;
                if (cnt_expire) begin
                    finish = 1'b1;
                end
            end
            HOLD: begin
                if (frame_strobe_i) begin
                    state_d  = APPLY;
                    ftws_d   = ftws_step_w;
                    update_d = 1'b1;
                    meas_d   = 1'b0;
                    pidx_d   = pidx_q + W_PTS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            meas_d = 1'b1;
            if (last_point) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = HOLD;
            end
        end

        if (state_q != IDLE) begin
            if (abort_i) begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                meas_d   = 1'b0;
                ftws_d   = ftws_q;
                pidx_d   = pidx_q;
                update_d = 1'b0;
                done_d   = 1'b0;
            end else if (commit_i) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sample_clk_i or negedge sample_rst_n_i) begin
        if (!sample_rst_n_i) begin
            state_q  <= IDLE;
            ftws_q   <= '{default: '0};
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            meas_q   <= 1'b0;
            pidx_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sweep_q  <= 1'b0;
            step_q   <= '0;
            settle_q <= '0;
            npts_q   <= '0;
        end else begin
            state_q  <= state_d;
            ftws_q   <= ftws_d;
            update_q <= update_d;
            busy_q   <= busy_d;
            meas_q   <= meas_d;
            pidx_q   <= pidx_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sweep_q  <= sweep_d;
            step_q   <= step_d;
            settle_q <= settle_d;
            npts_q   <= npts_d;
        end
    end

    always_ff @(posedge sample_clk_i or negedge sample_rst_n_i) begin
        if (!sample_rst_n_i) begin
            shadow_q <= '{default: '0};
        end else if (wr_en_i) begin
            shadow_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign ftws_0_o     = ftws_q[0];
    assign ftws_1_o     = ftws_q[1];
    assign ftws_2_o     = ftws_q[2];
    assign ftws_3_o     = ftws_q[3];
    assign update_ftw_o = update_q;
    assign busy_o       = busy_q;
    assign meas_valid_o = meas_q;
    assign point_idx_o  = pidx_q;
    assign sweep_done_o = done_q;
    assign commit_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vvm_ftw_sequencer.sv
`default_nettype none
// =============================================================================
// tb_vvm_ftw_sequencer : directed stimulus, cycle model compare, literal pins
// Rev 1.0
// =============================================================================
module tb_vvm_ftw_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        abort = 1'b0;
    logic        sweep_en = 1'b0;
    logic [31:0] ftw_step = '0;
    logic [15:0] sweep_points = '0;
    logic [3:0]  settle_frames = '0;
    logic        frame_strobe = 1'b0;
    logic [31:0] ftws [4];
    logic        update_ftw, busy, meas_valid, sweep_done, commit_err;
    logic [15:0] point_idx;

    always #5 clk = ~clk;

    vvm_ftw_sequencer dut (
        .sample_clk_i    (clk),
        .sample_rst_n_i  (rst_n),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .commit_i        (commit),
        .abort_i         (abort),
        .sweep_en_i      (sweep_en),
        .ftw_step_i      (ftw_step),
        .sweep_points_i  (sweep_points),
        .settle_frames_i (settle_frames),
        .frame_strobe_i  (frame_strobe),
        .ftws_0_o        (ftws[0]),
        .ftws_1_o        (ftws[1]),
        .ftws_2_o        (ftws[2]),
        .ftws_3_o        (ftws[3]),
        .update_ftw_o    (update_ftw),
        .busy_o          (busy),
        .meas_valid_o    (meas_valid),
        .point_idx_o     (point_idx),
        .sweep_done_o    (sweep_done),
        .commit_err_o    (commit_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 awaiting frame, 2 just applied, 3 discarding frames, 4 measuring
    logic [31:0] m_shadow [4];
    logic [31:0] m_ftw [4];
    logic        m_upd, m_busy, m_mv, m_done, m_err, m_sweep;
    int          m_phase, m_left, m_pidx, m_npts, m_settle;
    logic [31:0] m_step;

    task automatic model_point_settled();
        m_mv = 1'b1;
        if (!m_sweep || m_pidx == m_npts - 1) begin
            m_phase = 0;
            m_busy  = 1'b0;
            m_done  = 1'b1;
        end else begin
            m_phase = 4;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    m_shadow[i] = '0;
                    m_ftw[i]    = '0;
                end
                {m_upd, m_busy, m_mv, m_done, m_err, m_sweep} = '0;
                m_phase = 0; m_left = 0; m_pidx = 0; m_npts = 1; m_settle = 0; m_step = '0;
            end else begin
                m_upd = 1'b0; m_done = 1'b0; m_err = 1'b0;
                if (m_phase != 0 && abort) begin
                    m_phase = 0; m_busy = 1'b0; m_mv = 1'b0;
                end else begin
                    if (m_phase != 0 && commit) m_err = 1'b1;
                    if (m_phase == 0) begin
                        if (commit) begin
                            m_phase = 1; m_busy = 1'b1; m_mv = 1'b0; m_pidx = 0;
                            m_sweep = sweep_en; m_step = ftw_step; m_settle = int'(settle_frames);
                            m_npts = (sweep_points == 0) ? 1 : int'(sweep_points);
                        end
                    end else if (m_phase == 1) begin
                        if (frame_strobe) begin
                            for (int i = 0; i < 4; i++) m_ftw[i] = m_shadow[i];
                            m_upd = 1'b1; m_phase = 2;
                        end
                    end else if (m_phase == 2) begin
                        m_left = m_settle;
                        if (m_left == 0) model_point_settled();
                        else m_phase = 3;
                    end else if (m_phase == 3) begin
                        if (frame_strobe) begin
                            m_left--;
                            if (m_left == 0) model_point_settled();
                        end
                    end else begin
                        if (frame_strobe) begin
                            for (int i = 0; i < 4; i++) m_ftw[i] = m_ftw[i] + m_step;
                            m_pidx++; m_mv = 1'b0; m_upd = 1'b1; m_phase = 2;
                        end
                    end
                end
                if (wr_en) m_shadow[wr_addr] = wr_data;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 4; i++) check($sformatf("ftws_%0d", i), ftws[i], m_ftw[i]);
                check("update_ftw", 32'(update_ftw), 32'(m_upd));
                check("busy", 32'(busy), 32'(m_busy));
                check("meas_valid", 32'(meas_valid), 32'(m_mv));
                check("point_idx", 32'(point_idx), 32'(m_pidx));
                check("sweep_done", 32'(sweep_done), 32'(m_done));
                check("commit_err", 32'(commit_err), 32'(m_err));
            end
        end
    end

    // ---------------- event monitor ----------------
    int          cyc = 0;
    int          n_upd = 0, n_done = 0, n_err = 0;
    int          upd_cyc = 0, mv_cyc = 0, done_cyc = 0;
    logic        prev_mv = 1'b0;
    logic [31:0] q_ftw0 [$];
    logic [15:0] q_pidx [$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (update_ftw) begin
                n_upd++; upd_cyc = cyc;
                q_ftw0.push_back(ftws[0]);
                q_pidx.push_back(point_idx);
            end
            if (sweep_done) begin n_done++; done_cyc = cyc; end
            if (commit_err) n_err++;
            if (meas_valid && !prev_mv) mv_cyc = cyc;
            prev_mv = meas_valid;
        end else begin
            prev_mv = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        commit = 1'b0; abort = 1'b0; wr_en = 1'b0; frame_strobe = 1'b0;
    endtask

    task automatic write_sh(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
    endtask

    task automatic do_commit(input logic sw, input logic [31:0] st, input logic [15:0] pts, input logic [3:0] sf);
        sweep_en = sw; ftw_step = st; sweep_points = pts; settle_frames = sf;
        commit = 1'b1;
        tick();
    endtask

    task automatic frame(input int gap);
        repeat (gap - 1) tick();
        frame_strobe = 1'b1;
        tick();
    endtask

    int b_upd, b_done;

    initial begin
        // reset state
        repeat (3) tick();
        for (int i = 0; i < 4; i++) check("reset ftws", ftws[i], 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset update", 32'(update_ftw), 32'h0);
        check("reset meas", 32'(meas_valid), 32'h0);
        check("reset pidx", 32'(point_idx), 32'h0);
        rst_n = 1'b1;
        tick();

        // single apply, settle 2, with a commit while busy
        write_sh(2'd0, 32'h10000000); write_sh(2'd1, 32'h20000000);
        write_sh(2'd2, 32'h30000000); write_sh(2'd3, 32'h40000000);
        b_upd = n_upd; b_done = n_done;
        do_commit(1'b0, 32'h0, 16'd1, 4'd2);
        frame(100);
        repeat (49) tick();
        commit = 1'b1; tick();
        repeat (49) tick();
        frame_strobe = 1'b1; tick();
        frame(100);
        repeat (5) tick();
        check("t1 ftws_0", ftws[0], 32'h10000000);
        check("t1 ftws_3", ftws[3], 32'h40000000);
        check("t1 meas_valid", 32'(meas_valid), 32'h1);
        check("t1 busy", 32'(busy), 32'h0);
        check("t1 upd count", 32'(n_upd - b_upd), 32'd1);
        check("t1 done count", 32'(n_done - b_done), 32'd1);
        check("t1 err count", 32'(n_err), 32'd1);
        check("t1 settle latency", 32'(mv_cyc - upd_cyc), 32'd200);
        check("t1 done with meas", 32'(done_cyc), 32'(mv_cyc));

        // sweep with wrap
        for (int i = 0; i < 4; i++) write_sh(2'(i), 32'hFFFFFFF0);
        q_ftw0.delete(); q_pidx.delete();
        b_upd = n_upd; b_done = n_done;
        do_commit(1'b1, 32'h10, 16'd3, 4'd1);
        repeat (6) frame(20);
        repeat (5) tick();
        check("t2 upd count", 32'(n_upd - b_upd), 32'd3);
        check("t2 done count", 32'(n_done - b_done), 32'd1);
        if (q_ftw0.size() == 3) begin
            check("t2 ftw p0", q_ftw0[0], 32'hFFFFFFF0);
            check("t2 ftw p1", q_ftw0[1], 32'h00000000);
            check("t2 ftw p2", q_ftw0[2], 32'h00000010);
            check("t2 pidx p1", 32'(q_pidx[1]), 32'd1);
            check("t2 pidx p2", 32'(q_pidx[2]), 32'd2);
        end
        check("t2 ftws_3 final", ftws[3], 32'h00000010);

        // settle 0, sweep_points 0
        b_upd = n_upd; b_done = n_done;
        do_commit(1'b1, 32'h10, 16'd0, 4'd0);
        frame(5);
        repeat (5) tick();
        check("t3 upd count", 32'(n_upd - b_upd), 32'd1);
        check("t3 done count", 32'(n_done - b_done), 32'd1);
        check("t3 meas latency", 32'(mv_cyc - upd_cyc), 32'd1);
        check("t3 meas", 32'(meas_valid), 32'h1);

        // write coincident with the triggering strobe
        write_sh(2'd1, 32'h11111111);
        do_commit(1'b0, 32'h0, 16'd1, 4'd0);
        tick();
        frame_strobe = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'hAAAA0000;
        tick();
        repeat (3) tick();
        check("t4 old shadow", ftws[1], 32'h11111111);
        do_commit(1'b0, 32'h0, 16'd1, 4'd0);
        frame(3);
        repeat (3) tick();
        check("t4 new shadow", ftws[1], 32'hAAAA0000);
        check("t4 ch0", ftws[0], 32'hFFFFFFF0);

        // abort during settle
        write_sh(2'd0, 32'h00000055);
        b_done = n_done;
        do_commit(1'b0, 32'h0, 16'd1, 4'd3);
        frame(4);
        repeat (3) tick();
        check("t5 applied", ftws[0], 32'h00000055);
        frame(4);
        tick();
        abort = 1'b1; tick();
        check("t5 busy", 32'(busy), 32'h0);
        check("t5 meas", 32'(meas_valid), 32'h0);
        check("t5 ftws_0 kept", ftws[0], 32'h00000055);
        check("t5 ftws_1 kept", ftws[1], 32'hAAAA0000);
        b_upd = n_upd;
        repeat (3) frame(4);
        check("t5 no done", 32'(n_done - b_done), 32'd0);
        check("t5 no upd", 32'(n_upd - b_upd), 32'd0);

        // async reset while measuring in a sweep
        do_commit(1'b1, 32'h1, 16'd4, 4'd1);
        frame(5);
        frame(5);
        repeat (2) tick();
        check("t6 in hold", 32'(meas_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("t6 rst ftws_0", ftws[0], 32'h0);
        check("t6 rst ftws_1", ftws[1], 32'h0);
        check("t6 rst busy", 32'(busy), 32'h0);
        check("t6 rst meas", 32'(meas_valid), 32'h0);
        check("t6 rst update", 32'(update_ftw), 32'h0);
        check("t6 rst pidx", 32'(point_idx), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        b_upd = n_upd;
        repeat (3) frame(5);
        check("t6 no upd after reset", 32'(n_upd - b_upd), 32'd0);
        check("t6 busy after reset", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
